// File: rtl/wb_to_vmemem_bridge_if.sv
// Wishbone B4 pipelined slave-side bundle for wb_to_vmemem_bridge.
// Member names keep the bridge's original port names so the signals stay traceable.
interface wb_to_vmemem_bridge_if #(
  parameter int unsigned AW = 8
) ();
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_we_i;
  logic [AW-1:0] wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          wb_stall_o;
  logic [31:0]   wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_ack_o, wb_err_o, wb_stall_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_ack_o, wb_err_o, wb_stall_o, wb_dat_o
  );
endinterface

// File: rtl/wb_to_vmemem_bridge.sv
// Pipelined Wishbone B4 slave to single-cycle VMERdMem/VMEWrMem strobe bridge.
// One transfer at a time: strobe the bank, wait for the matching done, answer ack/err.
// Optional bus-timeout watchdog enabled by defining WB_BRIDGE_TIMEOUT_EN.
module wb_to_vmemem_bridge #(
  parameter int unsigned AW      = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wb_to_vmemem_bridge_if.slave  wb,
  output logic [AW-3:0]         mem_adr_o,
  output logic [31:0]           mem_wr_data_o,
  output logic                  mem_rd_o,
  output logic                  mem_wr_o,
  input  logic [31:0]           mem_rd_data_i,
  input  logic                  mem_rd_done_i,
  input  logic                  mem_wr_done_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_RD = 2'd1,
    WAIT_WR = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          stall_q, stall_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          drop_q, drop_d;
  logic [31:0]   rdat_q, rdat_d;
  logic [31:0]   wdat_q, wdat_d;
  logic [AW-3:0] adr_q, adr_d;

  logic accept;
  logic full_write;
  logic done;
  logic dropped;
  logic timeout_hit;
  logic adr_lsb_unused;

  assign accept     = wb.wb_cyc_i & wb.wb_stb_i & ~stall_q;
  assign full_write = (wb.wb_sel_i == 4'hF);
  assign done       = ((state_q == WAIT_RD) & mem_rd_done_i) |
                      ((state_q == WAIT_WR) & mem_wr_done_i);
  // Once the master abandons the cycle, the response stays suppressed even if cyc returns.
  assign dropped    = drop_q | ~wb.wb_cyc_i;

  // Byte-lane bits of the address carry no meaning for word-wide banks.
  assign adr_lsb_unused = ^wb.wb_adr_i[1:0];

`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  logic [15:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == TIMEOUT_CNT);

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Clear on each bank strobe, count every cycle spent waiting for done.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (accept && (!wb.wb_we_i || full_write)) cnt_d = '0;
    end else if (!done) begin
      cnt_d = cnt_q + 16'd1;
    end
  end
`else
  localparam int unsigned timeout_unused = TIMEOUT;

  assign timeout_hit = 1'b0;
`endif

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      drop_q  <= 1'b0;
      rdat_q  <= '0;
      wdat_q  <= '0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      drop_q  <= drop_d;
      rdat_q  <= rdat_d;
      wdat_q  <= wdat_d;
      adr_q   <= adr_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!wb.wb_we_i)     state_d = WAIT_RD;
          else if (full_write) state_d = WAIT_WR;
        end
      end
      WAIT_RD, WAIT_WR: begin
        if (done || timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; responses land one cycle after their cause.
  always_comb begin
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    drop_d  = drop_q;
    rdat_d  = rdat_q;
    wdat_d  = wdat_q;
    adr_d   = adr_q;
    stall_d = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!wb.wb_we_i) begin
            rd_d   = 1'b1;
            adr_d  = wb.wb_adr_i[AW-1:2];
            drop_d = 1'b0;
          end else if (full_write) begin
            wr_d   = 1'b1;
            adr_d  = wb.wb_adr_i[AW-1:2];
            wdat_d = wb.wb_dat_i;
            drop_d = 1'b0;
          end else begin
            err_d  = 1'b1;
          end
        end
      end
      WAIT_RD, WAIT_WR: begin
        drop_d = dropped;
        if (done) begin
          if (state_q == WAIT_RD) rdat_d = mem_rd_data_i;
          ack_d = ~dropped;
        end else if (timeout_hit) begin
          err_d = ~dropped;
        end
      end
      default: ;
    endcase
  end

  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_err_o   = err_q;
  assign wb.wb_stall_o = stall_q;
  assign wb.wb_dat_o   = rdat_q;
  assign mem_adr_o     = adr_q;
  assign mem_wr_data_o = wdat_q;
  assign mem_rd_o      = rd_q;
  assign mem_wr_o      = wr_q;

endmodule
